// File: rtl/sr_pkg.sv
// Shared definitions for the 3x3 window scheduler: state encoding, tap offsets, defaults.
package sr_pkg;

   localparam int unsigned DEF_WIDTH       = 320;
   localparam int unsigned DEF_HEIGHT      = 240;
   localparam int unsigned DEF_PIXEL_WIDTH = 16;
   localparam int unsigned DEF_ADDR_WIDTH  = 17;

   localparam int unsigned COORD_W  = 16;
   localparam int unsigned TAP_W    = 4;
   localparam int unsigned NUM_TAPS = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_START,
      ST_COMPUTE,
      ST_PUSH,
      ST_DONE
   } state_e;

   typedef logic signed [1:0] tap_off_t;

   // Row-major tap order: tap k sits at (k%3-1, k/3-1) relative to the centre.
   localparam tap_off_t TAP_DX [NUM_TAPS] = '{2'sb11, 2'sb00, 2'sb01,
                                             2'sb11, 2'sb00, 2'sb01,
                                             2'sb11, 2'sb00, 2'sb01};
   localparam tap_off_t TAP_DY [NUM_TAPS] = '{2'sb11, 2'sb11, 2'sb11,
                                             2'sb00, 2'sb00, 2'sb00,
                                             2'sb01, 2'sb01, 2'sb01};

endpackage

// File: rtl/sr_tap_addr_gen.sv
// Frame-buffer address and in-bounds flag for tap k around centre (x,y).
module sr_tap_addr_gen
   import sr_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned HEIGHT     = DEF_HEIGHT,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic [COORD_W-1:0]    x_i,
   input  logic [COORD_W-1:0]    y_i,
   input  logic [TAP_W-1:0]      k_i,
   output logic [ADDR_WIDTH-1:0] addr_c,
   output logic                  in_bounds_c
);

   localparam int unsigned SW = COORD_W + 2;
   localparam logic signed [SW-1:0] ZERO  = '0;
   localparam logic signed [SW-1:0] X_MAX = SW'(WIDTH - 1);
   localparam logic signed [SW-1:0] Y_MAX = SW'(HEIGHT - 1);

   logic signed [SW-1:0] tx;
   logic signed [SW-1:0] ty;
   logic [SW-1:0]        row;
   logic [SW-1:0]        col;
   logic [31:0]          lin;

   // Signed neighbour coordinates; out-of-frame taps fall back to the centre address.
   always_comb begin
      tx          = $signed({2'b00, x_i}) + SW'(TAP_DX[k_i]);
      ty          = $signed({2'b00, y_i}) + SW'(TAP_DY[k_i]);
      in_bounds_c = (tx >= ZERO) && (tx <= X_MAX) && (ty >= ZERO) && (ty <= Y_MAX);
      row         = in_bounds_c ? $unsigned(ty) : {2'b00, y_i};
      col         = in_bounds_c ? $unsigned(tx) : {2'b00, x_i};
      lin         = 32'(row) * 32'(WIDTH) + 32'(col);
      addr_c      = ADDR_WIDTH'(lin);
   end

endmodule

// File: rtl/sr_window_scheduler.sv
// Walks a resident frame pixel by pixel, gathers each 3x3 window from the frame buffer,
// hands it to the compute engine and pushes the engine result into the output FIFO.
module sr_window_scheduler
   import sr_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned HEIGHT      = DEF_HEIGHT,
   parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        frame_ready,
   output logic [ADDR_WIDTH-1:0]       bram_addr,
   input  logic [PIXEL_WIDTH-1:0]      bram_dout,
   output logic [9*PIXEL_WIDTH-1:0]    neighborhood,
   output logic [COORD_W-1:0]          x_out,
   output logic [COORD_W-1:0]          y_out,
   output logic                        start_process,
   input  logic                        pixel_done,
   input  logic [PIXEL_WIDTH-1:0]      processed_pixel,
   output logic                        fifo_write,
   output logic [PIXEL_WIDTH-1:0]      fifo_data,
   input  logic                        fifo_full,
   output logic                        busy,
   output logic                        frame_done
);

   state_e                  state_q, state_d;
   logic [COORD_W-1:0]      x_q, x_d;
   logic [COORD_W-1:0]      y_q, y_d;
   logic [TAP_W-1:0]        k_q, k_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    inb_q, inb_d;
   logic                    cap_vld_q;
   logic [TAP_W-1:0]        cap_k_q;
   logic                    cap_inb_q;
   logic [NUM_TAPS-1:0][PIXEL_WIDTH-1:0] win_q;
   logic [PIXEL_WIDTH-1:0]  data_q, data_d;
   logic                    start_q;
   logic                    wr_q;
   logic                    busy_q;
   logic                    done_q;

   logic [ADDR_WIDTH-1:0]   gen_addr;
   logic                    gen_inb;
   logic                    last_col;
   logic                    last_pix;

   // Address of the tap that will be presented next cycle.
   sr_tap_addr_gen #(
      .WIDTH      (WIDTH),
      .HEIGHT     (HEIGHT),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .x_i         (x_d),
      .y_i         (y_d),
      .k_i         (k_d),
      .addr_c      (gen_addr),
      .in_bounds_c (gen_inb)
   );

   assign last_col = (x_q == COORD_W'(WIDTH - 1));
   assign last_pix = last_col && (y_q == COORD_W'(HEIGHT - 1));

   // Next-state, coordinate and tap-counter logic.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      data_d  = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (frame_ready) begin
               state_d = ST_FETCH;
               x_d     = '0;
               y_d     = '0;
               k_d     = '0;
            end
         end
         ST_FETCH: begin
            if (k_q == TAP_W'(NUM_TAPS - 1)) begin
               state_d = ST_DRAIN;
            end else begin
               k_d = k_q + TAP_W'(1);
            end
         end
         ST_DRAIN:   state_d = ST_START;
         ST_START:   state_d = ST_COMPUTE;
         ST_COMPUTE: begin
            if (pixel_done) begin
               data_d  = processed_pixel;
               state_d = ST_PUSH;
            end
         end
         ST_PUSH: begin
            if (!fifo_full) begin
               if (last_pix) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FETCH;
                  k_d     = '0;
                  if (last_col) begin
                     x_d = '0;
                     y_d = y_q + COORD_W'(1);
                  end else begin
                     x_d = x_q + COORD_W'(1);
                  end
               end
            end
         end
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      addr_d = (state_d == ST_FETCH) ? gen_addr : addr_q;
      inb_d  = (state_d == ST_FETCH) ? gen_inb  : inb_q;
   end

   // State, window capture and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         k_q       <= '0;
         addr_q    <= '0;
         inb_q     <= 1'b0;
         cap_vld_q <= 1'b0;
         cap_k_q   <= '0;
         cap_inb_q <= 1'b0;
         win_q     <= '0;
         data_q    <= '0;
         start_q   <= 1'b0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         k_q       <= k_d;
         addr_q    <= addr_d;
         inb_q     <= inb_d;
         // Read data for the tap issued last cycle arrives now.
         cap_vld_q <= (state_q == ST_FETCH);
         cap_k_q   <= k_q;
         cap_inb_q <= inb_q;
         if (cap_vld_q) begin
            win_q[cap_k_q] <= cap_inb_q ? bram_dout : '0;
         end
         data_q    <= data_d;
         start_q   <= (state_d == ST_START);
         wr_q      <= (state_q == ST_PUSH) && !fifo_full;
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_q == ST_DONE);
      end
   end

   assign bram_addr     = addr_q;
   assign neighborhood  = win_q;
   assign x_out         = x_q;
   assign y_out         = y_q;
   assign start_process = start_q;
   assign fifo_write    = wr_q;
   assign fifo_data     = data_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;

endmodule
